// File: rtl/rom_frame_pkg.sv
// Shared constants and state encoding for the command-frame deframer.
package rom_frame_pkg;

  localparam logic [7:0] SYNC_BYTE = 8'hA5;
  localparam logic [1:0] ERR_LEN   = 2'd1;
  localparam logic [1:0] ERR_CHK   = 2'd2;

  typedef enum logic [2:0] {
    S_SYNC = 3'd0,
    S_OP   = 3'd1,
    S_ADDR = 3'd2,
    S_LEN  = 3'd3,
    S_DATA = 3'd4,
    S_CHK  = 3'd5,
    S_EMIT = 3'd6
  } deframe_state_t;

endpackage

// File: rtl/rom_deframer_if.sv
// Addressed beat stream from the deframer to the ROM front end.
// A beat transfers on a rising clk edge where req_valid && req_ready; while
// req_valid is high and req_ready low, every req_* field holds its value.
interface rom_deframer_if;

  logic        req_valid;
  logic        req_ready;
  logic [7:0]  req_opcode;
  logic [31:0] req_addr;
  logic [31:0] req_data;
  logic        req_last;

  modport master (
    output req_valid, req_opcode, req_addr, req_data, req_last,
    input  req_ready
  );

  modport slave (
    input  req_valid, req_opcode, req_addr, req_data, req_last,
    output req_ready
  );

endinterface

// File: rtl/frame_buf.sv
// Payload word buffer: byte-lane synchronous write, combinational read.
module frame_buf #(
  parameter int DEPTH = 16,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [1:0]    lane,
  input  logic [7:0]    wbyte,
  input  logic [AW-1:0] raddr,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr][{lane, 3'b000} +: 8] <= wbyte;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/rom_deframer.sv
// Parses SYNC/OP/ADDR/LEN/payload/CHK frames from the response FIFO and
// replays checked frames as addressed 32-bit beats.
module rom_deframer
  import rom_frame_pkg::*;
#(
  parameter int MAX_WORDS = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  almost_empty,
  output logic                  rd_en,
  input  logic [7:0]            din,
  rom_deframer_if.master        req,
  output logic                  err_valid,
  output logic [1:0]            err_code,
  output logic [15:0]           frame_ok_cnt,
  output logic [2:0]            state_dbg
);

  localparam int PW = $clog2(MAX_WORDS);
  localparam int CW = PW + 2;

  deframe_state_t state;
  logic           byte_vld;
  logic [CW-1:0]  cnt;
  logic [7:0]     chk;
  logic [7:0]     op_r;
  logic [31:0]    addr_r;
  logic [7:0]     len_r;
  logic [PW-1:0]  beat;
  logic [31:0]    buf_rdata;
  logic           buf_we;
  logic           emit;
  logic           beat_last;
  logic [9:0]     data_end;

  assign state_dbg = state;

  // One pop in flight at a time: the byte lands while byte_vld is high.
  assign rd_en = rst_n && !almost_empty && !byte_vld &&
                 (state inside {S_SYNC, S_OP, S_ADDR, S_LEN, S_DATA, S_CHK});

  assign buf_we   = byte_vld && (state == S_DATA);
  assign data_end = 10'({len_r, 2'b00}) - 10'd1;

  frame_buf #(.DEPTH(MAX_WORDS)) u_buf (
    .clk   (clk),
    .we    (buf_we),
    .waddr (cnt[CW-1:2]),
    .lane  (cnt[1:0]),
    .wbyte (din),
    .raddr (beat),
    .rdata (buf_rdata)
  );

  always_comb begin
    emit      = (state == S_EMIT);
    beat_last = (len_r == 8'd0) || (8'(beat) == len_r - 8'd1);
    req.req_valid  = emit;
    req.req_opcode = emit ? op_r : 8'd0;
    req.req_addr   = emit ? addr_r + 32'({beat, 2'b00}) : 32'd0;
    req.req_data   = (emit && len_r != 8'd0) ? buf_rdata : 32'd0;
    req.req_last   = emit && beat_last;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= S_SYNC;
      byte_vld     <= 1'b0;
      cnt          <= '0;
      chk          <= 8'd0;
      op_r         <= 8'd0;
      addr_r       <= 32'd0;
      len_r        <= 8'd0;
      beat         <= '0;
      err_valid    <= 1'b0;
      err_code     <= 2'd0;
      frame_ok_cnt <= 16'd0;
    end else begin
      byte_vld  <= rd_en;
      err_valid <= 1'b0;
      case (state)
        S_SYNC: begin
          if (byte_vld && din == SYNC_BYTE) state <= S_OP;
        end
        S_OP: begin
          if (byte_vld) begin
            op_r  <= din;
            chk   <= din;
            cnt   <= '0;
            state <= S_ADDR;
          end
        end
        S_ADDR: begin
          if (byte_vld) begin
            addr_r[{cnt[1:0], 3'b000} +: 8] <= din;
            chk <= chk ^ din;
            cnt <= cnt + 1'b1;
            if (cnt[1:0] == 2'd3) state <= S_LEN;
          end
        end
        S_LEN: begin
          if (byte_vld) begin
            len_r <= din;
            chk   <= chk ^ din;
            cnt   <= '0;
            if (din > 8'(MAX_WORDS)) begin
              err_valid <= 1'b1;
              err_code  <= ERR_LEN;
              state     <= S_SYNC;
            end else if (din == 8'd0) begin
              state <= S_CHK;
            end else begin
              state <= S_DATA;
            end
          end
        end
        S_DATA: begin
          if (byte_vld) begin
            chk <= chk ^ din;
            cnt <= cnt + 1'b1;
            if (10'(cnt) == data_end) state <= S_CHK;
          end
        end
        S_CHK: begin
          if (byte_vld) begin
            if (din == chk) begin
              beat         <= '0;
              frame_ok_cnt <= frame_ok_cnt + 16'd1;
              state        <= S_EMIT;
            end else begin
              err_valid <= 1'b1;
              err_code  <= ERR_CHK;
              state     <= S_SYNC;
            end
          end
        end
        S_EMIT: begin
          if (req.req_ready) begin
            if (beat_last) state <= S_SYNC;
            else           beat  <= beat + 1'b1;
          end
        end
        default: state <= S_SYNC;
      endcase
    end
  end

endmodule

// File: tb/tb_rom_deframer.sv
// Directed-vector bench for rom_deframer with a FIFO model and beat/error scoreboard.
module tb_rom_deframer;
  import rom_frame_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        almost_empty;
  logic        rd_en;
  logic [7:0]  din;
  logic        err_valid;
  logic [1:0]  err_code;
  logic [15:0] frame_ok_cnt;
  logic [2:0]  state_dbg;

  rom_deframer_if req_if ();

  rom_deframer #(.MAX_WORDS(16)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .almost_empty (almost_empty),
    .rd_en        (rd_en),
    .din          (din),
    .req          (req_if),
    .err_valid    (err_valid),
    .err_code     (err_code),
    .frame_ok_cnt (frame_ok_cnt),
    .state_dbg    (state_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests_run    = 0;
  int tests_failed = 0;

  logic [7:0]  fifo_q[$];
  logic [7:0]  frm[$];
  logic [72:0] exp_q[$];
  logic [1:0]  exp_err_q[$];

  logic force_ae    = 1'b0;
  logic ready_hold  = 1'b1;
  logic ready_tog   = 1'b0;
  logic prev_stall  = 1'b0;
  logic prev_err    = 1'b0;
  logic [72:0] prev_beat = '0;

  task automatic check_eq(input string tag, input logic [72:0] got, input logic [72:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [72:0] beat_of(input logic [7:0] op, input logic [31:0] a,
                                          input logic [31:0] d, input logic l);
    return {op, a, d, l};
  endfunction

  // driver tasks
  task automatic push_frm();
    foreach (frm[i]) fifo_q.push_back(frm[i]);
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(negedge clk);
      #2;
    end
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (!(fifo_q.size() == 0 && exp_q.size() == 0 && exp_err_q.size() == 0 &&
             state_dbg == S_SYNC) && n < 600) begin
      step(1);
      n++;
    end
    step(4);
    check_eq(tag, 73'(n < 600), 73'd1);
  endtask

  // FIFO model, ready pattern, and monitor/scoreboard all share the negedge
  always @(negedge clk) begin
    logic [72:0] got;
    logic [72:0] e;
    logic [1:0]  ee;
    almost_empty = force_ae || (fifo_q.size() == 0);
    req_if.req_ready = ready_tog ? !req_if.req_ready : ready_hold;
    #1;
    if (rd_en && fifo_q.size() > 0) din = fifo_q.pop_front();
    got = {req_if.req_opcode, req_if.req_addr, req_if.req_data, req_if.req_last};
    if (req_if.req_valid) begin
      check_eq("rd_en_during_emit", 73'(rd_en), 73'd0);
      if (prev_stall) check_eq("stall_hold", got, prev_beat);
      if (req_if.req_ready) begin
        e = (exp_q.size() > 0) ? exp_q.pop_front() : '1;
        check_eq("beat", got, e);
      end
    end
    prev_stall = req_if.req_valid && !req_if.req_ready;
    prev_beat  = got;
    if (err_valid) begin
      check_eq("err_pulse_width", 73'(prev_err), 73'd0);
      ee = (exp_err_q.size() > 0) ? exp_err_q.pop_front() : 2'd3;
      check_eq("err_code", 73'(err_code), 73'(ee));
    end
    prev_err = err_valid;
  end

  initial begin
    int n;
    rst_n = 1'b0;
    din   = 8'd0;
    almost_empty = 1'b1;
    req_if.req_ready = 1'b1;
    step(3);
    rst_n = 1'b1;
    step(1);
    check_eq("rst_req_valid", 73'(req_if.req_valid), 73'd0);
    check_eq("rst_err_valid", 73'(err_valid), 73'd0);
    check_eq("rst_ok_cnt", 73'(frame_ok_cnt), 73'd0);
    check_eq("rst_state", 73'(state_dbg), 73'(S_SYNC));

    // single-word frame
    frm = '{8'hA5, 8'h01, 8'h00, 8'h00, 8'h00, 8'h80, 8'h01,
            8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'hA2};
    exp_q.push_back(beat_of(8'h01, 32'h8000_0000, 32'hDEAD_BEEF, 1'b1));
    push_frm();
    wait_idle("idle_f1");
    check_eq("ok_cnt_f1", 73'(frame_ok_cnt), 73'd1);

    // LEN=0 frame
    frm = '{8'hA5, 8'h02, 8'h00, 8'h10, 8'h00, 8'h00, 8'h00, 8'h12};
    exp_q.push_back(beat_of(8'h02, 32'h0000_1000, 32'h0, 1'b1));
    push_frm();
    wait_idle("idle_len0");
    check_eq("ok_cnt_len0", 73'(frame_ok_cnt), 73'd2);

    // checksum mismatch, then a good frame
    frm = '{8'hA5, 8'h01, 8'h00, 8'h00, 8'h00, 8'h80, 8'h01,
            8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'hA3};
    exp_err_q.push_back(ERR_CHK);
    push_frm();
    wait_idle("idle_badchk");
    check_eq("ok_cnt_badchk", 73'(frame_ok_cnt), 73'd2);
    check_eq("err_code_hold", 73'(err_code), 73'(ERR_CHK));
    frm = '{8'hA5, 8'h01, 8'h00, 8'h00, 8'h00, 8'h80, 8'h01,
            8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'hA2};
    exp_q.push_back(beat_of(8'h01, 32'h8000_0000, 32'hDEAD_BEEF, 1'b1));
    push_frm();
    wait_idle("idle_after_badchk");
    check_eq("ok_cnt_after_badchk", 73'(frame_ok_cnt), 73'd3);

    // LEN too large, garbage, then a good frame
    frm = '{8'hA5, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h11,
            8'h00, 8'hFF, 8'h13,
            8'hA5, 8'h02, 8'h00, 8'h10, 8'h00, 8'h00, 8'h00, 8'h12};
    exp_err_q.push_back(ERR_LEN);
    exp_q.push_back(beat_of(8'h02, 32'h0000_1000, 32'h0, 1'b1));
    push_frm();
    wait_idle("idle_badlen");
    check_eq("ok_cnt_badlen", 73'(frame_ok_cnt), 73'd4);
    check_eq("err_code_len", 73'(err_code), 73'(ERR_LEN));

    // three words across the address wrap with a toggling ready
    frm = '{8'hA5, 8'h33, 8'hF8, 8'hFF, 8'hFF, 8'hFF, 8'h03,
            8'h44, 8'h33, 8'h22, 8'h11, 8'h88, 8'h77, 8'h66, 8'h55,
            8'hCC, 8'hBB, 8'hAA, 8'h99, 8'hFB};
    exp_q.push_back(beat_of(8'h33, 32'hFFFF_FFF8, 32'h1122_3344, 1'b0));
    exp_q.push_back(beat_of(8'h33, 32'hFFFF_FFFC, 32'h5566_7788, 1'b0));
    exp_q.push_back(beat_of(8'h33, 32'h0000_0000, 32'h99AA_BBCC, 1'b1));
    ready_tog = 1'b1;
    push_frm();
    wait_idle("idle_wrap");
    ready_tog = 1'b0;
    check_eq("ok_cnt_wrap", 73'(frame_ok_cnt), 73'd5);

    // almost_empty blocks pops
    force_ae = 1'b1;
    frm = '{8'hA5, 8'h02, 8'h00, 8'h10, 8'h00, 8'h00, 8'h00, 8'h12};
    push_frm();
    for (int i = 0; i < 6; i++) begin
      step(2);
      check_eq("ae_rd_en", 73'(rd_en), 73'd0);
    end
    check_eq("ae_ok_cnt", 73'(frame_ok_cnt), 73'd5);
    exp_q.push_back(beat_of(8'h02, 32'h0000_1000, 32'h0, 1'b1));
    force_ae = 1'b0;
    wait_idle("idle_ae");
    check_eq("ok_cnt_ae", 73'(frame_ok_cnt), 73'd6);

    // reset in the middle of a payload
    frm = '{8'hA5, 8'h33, 8'hF8, 8'hFF, 8'hFF, 8'hFF, 8'h03,
            8'h44, 8'h33, 8'h22, 8'h11, 8'h88, 8'h77, 8'h66, 8'h55,
            8'hCC, 8'hBB, 8'hAA, 8'h99, 8'hFB};
    push_frm();
    n = 0;
    while (state_dbg != S_DATA && n < 200) begin
      step(1);
      n++;
    end
    step(4);
    check_eq("reach_data", 73'(state_dbg), 73'(S_DATA));
    fifo_q.delete();
    rst_n = 1'b0;
    step(1);
    check_eq("mid_rst_rd_en", 73'(rd_en), 73'd0);
    check_eq("mid_rst_beat", {req_if.req_opcode, req_if.req_addr, req_if.req_data,
                              req_if.req_last}, 73'd0);
    check_eq("mid_rst_valid", 73'(req_if.req_valid), 73'd0);
    check_eq("mid_rst_err", 73'({err_valid, err_code}), 73'd0);
    check_eq("mid_rst_cnt", 73'(frame_ok_cnt), 73'd0);
    rst_n = 1'b1;
    step(30);
    check_eq("post_rst_state", 73'(state_dbg), 73'(S_SYNC));
    check_eq("post_rst_cnt", 73'(frame_ok_cnt), 73'd0);

    frm = '{8'hA5, 8'h01, 8'h00, 8'h00, 8'h00, 8'h80, 8'h01,
            8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'hA2};
    exp_q.push_back(beat_of(8'h01, 32'h8000_0000, 32'hDEAD_BEEF, 1'b1));
    push_frm();
    wait_idle("idle_post_rst");
    check_eq("ok_cnt_post_rst", 73'(frame_ok_cnt), 73'd1);
    check_eq("beats_left", 73'(exp_q.size()), 73'd0);
    check_eq("errs_left", 73'(exp_err_q.size()), 73'd0);

    // final report
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/rom_deframer.md
# rom_deframer

Command-frame parser on the host-to-device path of the USB loopback design. Pops bytes from the read side of the FT-clock-to-system-clock response FIFO, hunts for frame sync, and buffers up to `MAX_WORDS` payload words. It verifies an XOR checksum, then replays the frame as a valid/ready stream of addressed 32-bit beats for the ROM front end. Frames that fail checks are dropped whole, and each drop is reported by a one-cycle error pulse.

## Interface
- `MAX_WORDS`, 16: payload buffer depth in 32-bit words; legal LEN range 0..MAX_WORDS.
- `clk`  in  1  system clock; the only clock.
- `rst_n`  in  1  reset, synchronous, active-low.
- `almost_empty`  in  1  FIFO almost-empty flag; no pop while high.
- `rd_en`  out  1  FIFO pop request.
- `din`  in  8  FIFO read data, valid the cycle after `rd_en`.
- `req_valid`  out  1  beat valid.
- `req_ready`  in  1  beat accepted when high together with `req_valid`.
- `req_opcode`  out  8  frame opcode, passed through uninterpreted.
- `req_addr`  out  32  beat address.
- `req_data`  out  32  beat data.
- `req_last`  out  1  final beat of frame.
- `err_valid`  out  1  one-cycle drop pulse.
- `err_code`  out  2  1 = LEN too large, 2 = checksum mismatch; holds last value.
- `frame_ok_cnt`  out  16  count of accepted frames; wraps 0xFFFF→0.

## Operation
- Frame bytes, in order:
  - SYNC 0xA5
  - OP
  - ADDR[7:0], ADDR[15:8], ADDR[23:16], ADDR[31:24]
  - LEN
  - 4·LEN payload bytes, little-endian per word
  - CHK
- CHK is the XOR of every byte from OP through the last payload byte. SYNC is excluded.
- FSM states:
  - `S_SYNC`: a non-0xA5 byte is discarded silently and the state is unchanged; 0xA5 → `S_OP`.
  - `S_OP` → `S_ADDR` (4 bytes) → `S_LEN`.
  - From `S_LEN`:
    - LEN > MAX_WORDS: `err_code`=1, `err_valid` pulse, → `S_SYNC`. Trailing bytes are then resynchronised by hunting.
    - LEN = 0: → `S_CHK`.
    - Otherwise: → `S_DATA`.
  - `S_DATA`: collects 4·LEN bytes into the word buffer at index 0..LEN-1, then → `S_CHK`.
  - `S_CHK`:
    - Mismatch: `err_code`=2, `err_valid` pulse, buffer discarded, → `S_SYNC`.
    - Match: → `S_EMIT`, and `frame_ok_cnt` increments.
  - `S_EMIT`: presents beats in order; leaves for `S_SYNC` on the handshake of the last beat.
- Beat k, for LEN ≥ 1:
  - `req_addr` = ADDR + 4·k, mod 2^32, so the address wraps.
  - `req_data` = buffer[k].
  - `req_last` = (k == LEN-1).
- LEN = 0: exactly one beat, `req_data`=0, `req_last`=1.
- No FIFO pops occur in `S_EMIT`; the upstream FIFO absorbs back-pressure.
- Reset at any time:
  - all outputs are driven to 0;
  - the FSM returns to `S_SYNC`;
  - any in-flight FIFO byte is ignored, since the byte-valid flag is cleared.

## Timing
- Pop rule: `rd_en` = !`almost_empty` && state ∈ {`S_SYNC`..`S_CHK`} && !`byte_vld`.
  - `rd_en` is combinational from registered state.
  - `byte_vld` is `rd_en` registered.
- `din` is consumed on the edge where `byte_vld`=1. Maximum throughput is 1 byte per 2 cycles.
- Latency from CHK captured to `req_valid`=1 is 1 cycle.
- Beats advance one per cycle while `req_ready`=1.
- Beat fields are stable while `req_valid` && !`req_ready`.
- `err_valid` is asserted for exactly one cycle, the cycle after the offending byte is consumed.
- `req_valid` never coincides with `rd_en`.
- `frame_ok_cnt` updates in the same cycle that `req_valid` first rises.

## Structure
- Package `rom_frame_pkg` holds:
  - `SYNC_BYTE`=8'hA5;
  - `ERR_LEN`=2'd1 and `ERR_CHK`=2'd2;
  - state enum `deframe_state_t`.
- Sub-module `frame_buf`: MAX_WORDS×32 storage with synchronous byte-lane write and combinational read, indexed by `$clog2(MAX_WORDS)`-bit pointer.
- Top holds the FSM, byte counter, running XOR register, ADDR/OP/LEN registers, beat index, and frame counter.

## Test plan
- Write frame `A5 01 00 00 00 80 01 EF BE AD DE A2` with `req_ready`=1 → one beat: opcode 0x01, addr 0x80000000, data 0xDEADBEEF, last=1; `frame_ok_cnt`=1; no error.
- LEN=0 frame `A5 02 00 10 00 00 00 12` → one beat: addr 0x00001000, data 0, last=1.
- Same as case 1 but CHK=0xA3 → no beat, `err_valid` for 1 cycle with `err_code`=2, count unchanged. A following valid frame is accepted.
- LEN=0x11 with MAX_WORDS=16 → `err_code`=1 pulse, no beat. Garbage bytes `00 FF 13` then a valid frame → garbage is discarded silently and the frame is accepted.
- LEN=3 at ADDR=0xFFFFFFF8, `req_ready` toggling 1/0 → addresses FFFFFFF8, FFFFFFFC, 00000000 in order; data is held during stalls; last only on the third beat; `rd_en`=0 throughout emit.
- `almost_empty` held high → `rd_en`=0. Assert `rst_n`=0 mid-`S_DATA` → next cycle all outputs are 0, and the partial frame is never emitted.
